leaf_out_arbiter: RTL



---
 rtl/leaf_arb_pkg.sv | 14 +
 rtl/leaf_out_arbiter_rr_pick.sv | 33 +++
 rtl/leaf_out_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/leaf_arb_pkg.sv
// Shared types and default sizing for the leaf output arbiter.
package leaf_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_PAYLOAD_BITS = 32;
  localparam int DEF_BURST_LEN    = 16;
  localparam int DEF_TIMEOUT      = 8;

endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after rr_ptr,
// wrapping modulo NUM_REQ, so rr_ptr itself has the lowest priority.
module rr_pick
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
)
(
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any_req
);

  localparam int ID_W = $clog2(NUM_REQ);

  int cand;

  // Scan from rr_ptr+1 upward and keep the first hit.
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        idx     = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-locked arbiter feeding one leaf output port through a
// one-entry registered output stage.
// Optional feature macro: LEAF_ARB_TIMEOUT_EN -- when defined, a burst
// survives up to TIMEOUT-1 consecutive idle cycles from its owner; otherwise
// the first idle cycle ends the grant.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick next requester, no req_ack issued
// ST_GRANT | grant_id owns the port until burst end or gap release
module leaf_out_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int BURST_LEN    = DEF_BURST_LEN
`ifdef LEAF_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT      = DEF_TIMEOUT
`endif
)
(
  input  logic                            clk_user,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         out_din,
  output logic                            out_vld,
  input  logic                            out_ack,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  arb_state_t              state;
  arb_state_t              state_nxt;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         pick_idx;
  logic                    any_req;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [BEAT_W-1:0]       beat_inc;
  logic                    in_grant;
  logic                    sel_vld;
  logic [PAYLOAD_BITS-1:0] sel_word;
  logic                    can_load;
  logic                    accept;
  logic                    gap;
  logic                    burst_done;
  logic                    gap_release;
  logic                    load_grant;
  logic                    release_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (req_vld),
    .rr_ptr  (rr_ptr),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  assign in_grant   = (state == ST_GRANT);
  assign sel_vld    = req_vld[grant_id];
  assign sel_word   = req_din[grant_id*PAYLOAD_BITS +: PAYLOAD_BITS];
  // Output slot is free if empty or being drained this cycle.
  assign can_load   = !out_vld || out_ack;
  assign accept     = in_grant && can_load && sel_vld;
  // A gap is the owner going quiet; backpressure with data pending is not one.
  assign gap        = in_grant && !sel_vld;
  assign beat_inc   = beat_cnt + BEAT_W'(1);
  assign burst_done = accept && (beat_inc == BEAT_W'(BURST_LEN));
  assign busy       = in_grant;

  // Ack the owner whenever the output slot can take a word.
  always_comb begin
    req_ack = '0;
    if (in_grant && can_load) begin
      req_ack[grant_id] = 1'b1;
    end
  end

`ifdef LEAF_ARB_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_inc;

  assign gap_inc     = gap_cnt + GAP_W'(1);
  assign gap_release = gap && (gap_inc == GAP_W'(TIMEOUT));

  // Consecutive idle cycles of the owner; any valid cycle clears it.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (load_grant || (in_grant && sel_vld)) begin
      gap_cnt <= '0;
    end else if (gap) begin
      gap_cnt <= gap_inc;
    end
  end
`else
  assign gap_release = gap;
`endif

  // State register.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: grant on any request, release on burst end or gap.
  always_comb begin
    state_nxt     = state;
    load_grant    = 1'b0;
    release_grant = 1'b0;
    if (state == ST_IDLE) begin
      if (any_req) begin
        state_nxt  = ST_GRANT;
        load_grant = 1'b1;
      end
    end else begin
      if (burst_done || gap_release) begin
        state_nxt     = ST_IDLE;
        release_grant = 1'b1;
      end
    end
  end

  // Grant bookkeeping: owner, round-robin pointer, beat counter.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      grant_id <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      if (load_grant) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_inc;
      end
      if (release_grant) begin
        rr_ptr <= grant_id;
      end
    end
  end

  // One-entry output register; keeps draining regardless of FSM state.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_din <= '0;
    end else if (accept) begin
      out_vld <= 1'b1;
      out_din <= sel_word;
    end else if (out_ack) begin
      out_vld <= 1'b0;
    end
  end

endmodule
